// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets within
// the four-register I/O window and the vector table layout.
package irq_pkg;

  // Register offsets relative to IO_BASE.
  typedef enum logic [1:0] {
    REG_EN   = 2'd0,
    REG_PEND = 2'd1,
    REG_SET  = 2'd2,
    REG_IDX  = 2'd3
  } reg_off_e;

  // Number of registers in the I/O window.
  localparam int unsigned NREGS = 4;

  // Each vector occupies two program words.
  localparam int unsigned VEC_STRIDE = 2;

  // Vector address for a source index; wraps modulo 2^16.
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [2:0] idx);
    return base + (16'(idx) * 16'(VEC_STRIDE));
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for up to eight request lines.
// 'any' flags that at least one line is set; 'idx' is 0 when none is set.
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec,
  output logic         any,
  output logic [2:0]   idx
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    any = |vec;
    idx = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches rising edges of up to eight peripheral event
// lines into pending flags, masks them with an enable register and presents a
// registered request plus prioritized vector address to the CPU. The serviced
// flag is cleared by snooping the CPU's fetch of the vector address.
// Optional build macro IRQC_SYNC_EN inserts a 2-flop synchronizer on each
// source line so that 'src' may be asynchronous to 'clock'.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NSRC     = 8,
  parameter logic [7:0]  IO_BASE  = 8'h20,
  parameter logic [15:0] VEC_BASE = 16'h0002
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [7:0]      io_addr,
  input  logic            io_re,
  input  logic            io_we,
  input  logic [7:0]      io_wdata,
  output logic [7:0]      io_rdata,
  input  logic [15:0]     pm_addr,
  input  logic            pm_re,
  output logic            irq,
  output logic [15:0]     irq_addr
);

  // Source path into the edge detector.
  logic [NSRC-1:0] src_s;
  logic [NSRC-1:0] src_d;
  logic [NSRC-1:0] rise;

  // Software-visible state.
  logic [NSRC-1:0] en;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_next;

  // Index that produced the current irq_addr; the ack clears this bit.
  logic [2:0]      irq_idx;

  // Arbitration.
  logic [NSRC-1:0] act;
  logic            any;
  logic [2:0]      idx;

  // Bus decode.
  logic [7:0]      io_off;
  logic            io_hit;
  logic            we_en;
  logic            we_pend;
  logic            we_set;

  // Ack and per-source set/clear terms.
  logic            ack;
  logic [NSRC-1:0] ack_mask;
  logic [NSRC-1:0] set_mask;
  logic [NSRC-1:0] clr_mask;

  // Read enable carries no side effects; reads are purely combinational.
  logic            unused_io_re;
  assign unused_io_re = io_re;

`ifdef IRQC_SYNC_EN
  logic [NSRC-1:0] sync_1;
  logic [NSRC-1:0] sync_2;

  // Two-stage synchronizer for asynchronous event lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= src;
      sync_2 <= sync_1;
    end
  end

  assign src_s = sync_2;
`else
  assign src_s = src;
`endif

  // Previous-cycle copy of the source lines for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_d <= '0;
    end else begin
      src_d <= src_s;
    end
  end

  assign rise = src_s & ~src_d;

  // Address decode; the subtraction wraps so windows near 8'hFF still work.
  assign io_off  = io_addr - IO_BASE;
  assign io_hit  = (io_off < 8'(NREGS));
  assign we_en   = io_we && io_hit && (io_off[1:0] == REG_EN);
  assign we_pend = io_we && io_hit && (io_off[1:0] == REG_PEND);
  assign we_set  = io_we && io_hit && (io_off[1:0] == REG_SET);

  // The CPU acknowledges by fetching the vector currently on offer.
  assign ack = irq && pm_re && (pm_addr == irq_addr);

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign ack_mask[gi] = ack && (irq_idx == 3'(gi));
      assign set_mask[gi] = rise[gi] || (we_set && io_wdata[gi]);
      assign clr_mask[gi] = ack_mask[gi] || (we_pend && io_wdata[gi]);
    end
  endgenerate

  // Setting is applied after clearing so a coincident event is never lost.
  assign pend_next = (pend & ~clr_mask) | set_mask;

  // Enable and pending registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en   <= '0;
      pend <= '0;
    end else begin
      if (we_en) begin
        en <= io_wdata[NSRC-1:0];
      end
      pend <= pend_next;
    end
  end

  assign act = pend & en;

  irq_prio_enc #(
    .N   (NSRC)
  ) u_prio (
    .vec (act),
    .any (any),
    .idx (idx)
  );

  // Registered request and vector; the vector holds when nothing is active.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq      <= 1'b0;
      irq_addr <= VEC_BASE;
      irq_idx  <= 3'd0;
    end else begin
      irq <= any && !ack;
      if (any) begin
        irq_addr <= vec_addr(VEC_BASE, idx);
        irq_idx  <= idx;
      end
    end
  end

  // Read mux; unimplemented bits and out-of-window addresses read zero.
  always_comb begin
    io_rdata = 8'h00;
    if (io_hit) begin
      case (reg_off_e'(io_off[1:0]))
        REG_EN:   io_rdata[NSRC-1:0] = en;
        REG_PEND: io_rdata[NSRC-1:0] = pend;
        REG_SET:  io_rdata = 8'h00;
        REG_IDX:  io_rdata = {5'b00000, idx};
        default:  io_rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl (default build, no source synchronizer).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same offset, away from the active edge.
module tb_irq_ctrl;

  logic        clock;
  logic        reset;
  logic [7:0]  src;
  logic [7:0]  io_addr;
  logic        io_re;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic [15:0] pm_addr;
  logic        pm_re;
  logic        irq;
  logic [15:0] irq_addr;

  int tests_run;
  int tests_failed;

  irq_ctrl #(
    .NSRC     (8),
    .IO_BASE  (8'h20),
    .VEC_BASE (16'h0002)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .src      (src),
    .io_addr  (io_addr),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .pm_addr  (pm_addr),
    .pm_re    (pm_re),
    .irq      (irq),
    .irq_addr (irq_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Register write; takes effect at the next rising edge.
  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    io_addr  = addr;
    io_wdata = data;
    io_we    = 1'b1;
    tick();
    io_we    = 1'b0;
    $display("[TB] write 0x%02h <= 0x%02h", addr, data);
  endtask

  // Combinational register read.
  task automatic io_read(input logic [7:0] addr, output logic [7:0] data);
    io_addr = addr;
    io_re   = 1'b1;
    #1;
    data    = io_rdata;
    io_re   = 1'b0;
    $display("[TB] read  0x%02h => 0x%02h", addr, data);
  endtask

  // Vector fetch by the CPU for one cycle.
  task automatic fetch(input logic [15:0] addr);
    pm_addr = addr;
    pm_re   = 1'b1;
    tick();
    pm_re   = 1'b0;
    $display("[TB] fetch 0x%04h", addr);
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
    tests_run++;
    if (irq_addr !== 16'h0002) begin
      tests_failed++;
      $display("FAIL reset_irq_addr: got %h want 0002", irq_addr);
    end
    io_read(8'h20, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_en: got %h want 00", rd);
    end
    io_read(8'h21, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_pend: got %h want 00", rd);
    end
  endtask

  task automatic test_single();
    logic [7:0] rd;
    io_write(8'h20, 8'h04);
    src = 8'h04;
    tick();
    src = 8'h00;
    io_read(8'h21, rd);
    tests_run++;
    if (rd !== 8'h04) begin
      tests_failed++;
      $display("FAIL single_pend: got %h want 04", rd);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_irq_early: got %b want 0", irq);
    end
    tick();
    tests_run++;
    if (irq !== 1'b1 || irq_addr !== 16'h0006) begin
      tests_failed++;
      $display("FAIL single_irq: got irq=%b addr=%h want irq=1 addr=0006", irq, irq_addr);
    end
    io_read(8'h23, rd);
    tests_run++;
    if (rd !== 8'h02) begin
      tests_failed++;
      $display("FAIL single_idx: got %h want 02", rd);
    end
  endtask

  task automatic test_ack();
    logic [7:0] rd;
    fetch(16'h0006);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_irq: got %b want 0", irq);
    end
    io_read(8'h21, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("FAIL ack_pend: got %h want 00", rd);
    end
    tick();
    tick();
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_irq_stays_low: got %b want 0", irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    io_write(8'h20, 8'hFF);
    src = 8'h22;
    tick();
    src = 8'h00;
    tick();
    tests_run++;
    if (irq !== 1'b1 || irq_addr !== 16'h0004) begin
      tests_failed++;
      $display("FAIL b2b_first: got irq=%b addr=%h want irq=1 addr=0004", irq, irq_addr);
    end
    fetch(16'h0004);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_gap: got %b want 0", irq);
    end
    io_read(8'h21, rd);
    tests_run++;
    if (rd !== 8'h20) begin
      tests_failed++;
      $display("FAIL b2b_pend: got %h want 20", rd);
    end
    tick();
    tests_run++;
    if (irq !== 1'b1 || irq_addr !== 16'h000C) begin
      tests_failed++;
      $display("FAIL b2b_second: got irq=%b addr=%h want irq=1 addr=000c", irq, irq_addr);
    end
    fetch(16'h000C);
    tick();
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_done: got %b want 0", irq);
    end
  endtask

  task automatic test_enable_late();
    logic [7:0] rd;
    io_write(8'h20, 8'h00);
    src = 8'h08;
    tick();
    src = 8'h00;
    tick();
    io_read(8'h21, rd);
    tests_run++;
    if (rd !== 8'h08 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_masked: got pend=%h irq=%b want pend=08 irq=0", rd, irq);
    end
    io_write(8'h20, 8'h08);
    tick();
    tests_run++;
    if (irq !== 1'b1 || irq_addr !== 16'h0008) begin
      tests_failed++;
      $display("FAIL late_enable: got irq=%b addr=%h want irq=1 addr=0008", irq, irq_addr);
    end
    // Disabling drops the request but keeps the flag pending.
    io_write(8'h20, 8'h00);
    tick();
    io_read(8'h21, rd);
    tests_run++;
    if (irq !== 1'b0 || rd !== 8'h08) begin
      tests_failed++;
      $display("FAIL late_disable: got irq=%b pend=%h want irq=0 pend=08", irq, rd);
    end
    io_write(8'h20, 8'h08);
    tick();
    io_write(8'h21, 8'h08);
    tick();
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_clear: got %b want 0", irq);
    end
  endtask

  task automatic test_set_wins();
    logic [7:0] rd;
    io_write(8'h20, 8'h00);
    io_write(8'h22, 8'h01);
    // Rise on src[0] in the same cycle as a write-1 clear of PEND[0].
    src = 8'h01;
    io_write(8'h21, 8'h01);
    src = 8'h00;
    io_read(8'h21, rd);
    tests_run++;
    if (rd !== 8'h01) begin
      tests_failed++;
      $display("FAIL set_wins: got %h want 01", rd);
    end
    io_write(8'h21, 8'h01);
    io_read(8'h21, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("FAIL pend_w1c: got %h want 00", rd);
    end
    io_read(8'h22, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("FAIL set_reads_zero: got %h want 00", rd);
    end
    io_write(8'h20, 8'h80);
    io_write(8'h22, 8'h80);
    tick();
    tests_run++;
    if (irq !== 1'b1 || irq_addr !== 16'h0010) begin
      tests_failed++;
      $display("FAIL set_vec7: got irq=%b addr=%h want irq=1 addr=0010", irq, irq_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (irq !== 1'b0 || irq_addr !== 16'h0002) begin
      tests_failed++;
      $display("FAIL async_reset: got irq=%b addr=%h want irq=0 addr=0002", irq, irq_addr);
    end
    io_read(8'h20, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset_en: got %h want 00", rd);
    end
    io_read(8'h21, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset_pend: got %h want 00", rd);
    end
    tick();
    reset = 1'b0;
    tick();
    io_write(8'h20, 8'hFF);
    io_read(8'h30, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("FAIL outside_30: got %h want 00", rd);
    end
    io_read(8'h1F, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("FAIL outside_1f: got %h want 00", rd);
    end
    io_read(8'h20, rd);
    tests_run++;
    if (rd !== 8'hFF) begin
      tests_failed++;
      $display("FAIL en_readback: got %h want ff", rd);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b1;
    src      = 8'h00;
    io_addr  = 8'h00;
    io_re    = 1'b0;
    io_we    = 1'b0;
    io_wdata = 8'h00;
    pm_addr  = 16'h0000;
    pm_re    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    test_reset();
    test_single();
    test_ack();
    test_back_to_back();
    test_enable_late();
    test_set_wins();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller: the initiator side of the CPU's `irq`/`irq_addr` interface.
- Collects up to 8 peripheral event lines, latches rising edges into pending flags and masks them with an enable register.
- Drives a registered level request plus a prioritized vector address to the CPU.
- Software-visible through the CPU I/O register bus; clears the serviced flag by snooping the program-memory vector fetch.

Parameters:
- NSRC, 8, number of interrupt sources (1..8); unused register bits read 0.
- IO_BASE, 8'h20, I/O address of the first of four registers.
- VEC_BASE, 16'h0002, program word address of source 0's vector.

Ports:
- clock  in  1  master clock
- reset  in  1  asynchronous, active-high reset
- src  in  NSRC  peripheral event lines, synchronous to clock unless IRQC_SYNC_EN
- io_addr  in  8  I/O register address
- io_re  in  1  I/O read enable
- io_we  in  1  I/O write enable
- io_wdata  in  8  I/O write data
- io_rdata  out  8  I/O read data, combinational; 8'h00 when io_addr is outside the block
- pm_addr  in  16  CPU program address (snoop)
- pm_re  in  1  CPU program read enable (snoop)
- irq  out  1  interrupt request to CPU, registered
- irq_addr  out  16  interrupt vector address, registered

Behaviour:
- Reset values: `irq`=0, `irq_addr`=VEC_BASE, EN=0, PEND=0, `src_d`=0.
- Registers at IO_BASE+n:
  - +0 EN: R/W.
  - +1 PEND: read pending; write 1 clears the bit.
  - +2 SET: write 1 sets the pending bit; reads 8'h00.
  - +3 IDX: read-only, {5'b0, current winning index}.
- Writes take effect at the clock edge while `io_we`=1; `io_re` is informational only.
- Edge detect: `src_d` <= `src` each cycle; `rise` = `src` & ~`src_d`.
- A PEND bit is set on `rise` or a SET write; cleared by a PEND write-1 or an ack.
  - Set always wins over a clear in the same cycle, so no event is lost.
- Priority: `act` = PEND & EN; lowest set index wins; `idx` is computed combinationally.
- Outputs, registered every cycle:
  - `irq` <= |`act` & ~`ack`.
  - `irq_addr` <= VEC_BASE + {`idx`,1'b0}: 2-word vectors, 16-bit, wraps mod 2^16.
  - `irq_addr` holds its last value when `act`=0.
- Ack: `ack` = `irq` & `pm_re` & (`pm_addr` == `irq_addr`).
  - Clears PEND[index that produced current `irq_addr`].
  - Forces `irq`=0 on the next cycle.
  - Next request is re-evaluated one cycle later.
- Latency: `src` rise sampled at edge k -> PEND set after k -> `irq`/`irq_addr` valid after k+1.
- Disabling a source via EN while `irq` is high drops `irq` after the next edge if no other source is active.
  - PEND is retained.
- Enabling a source with PEND already set raises `irq` after the following edge.
- Simultaneous rises on several sources: all latch; served lowest-index first, one ack each.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); `irq` drops without an ack.

Optional Feature:
- IRQC_SYNC_EN defined:
  - Each `src` bit passes through a 2-flop synchronizer (reset 0) before edge detection.
  - Adds 2 cycles to edge-to-`irq` latency (total 4 edges); `src` may be asynchronous.
- Undefined:
  - No synchronizer; `src` must be synchronous to `clock`; latency as above.

Decomposition:
- Shared package `irq_pkg`: register offset constants (EN=0, PEND=1, SET=2, IDX=3) and the vector stride constant (2).
- Sub-module `irq_prio_enc` (NSRC-bit lowest-index priority encoder: outputs `any` and 3-bit `idx`) is natural.
- Edge detect, register file and ack logic live in `irq_ctrl`.

Test Plan:
- EN=8'h04, pulse `src`[2] for 1 cycle -> PEND=8'h04, `irq`=1 two edges after the sampled rise, `irq_addr`=16'h0006.
- Drive `pm_addr`=16'h0006 with `pm_re`=1 while `irq`=1 -> PEND=8'h00 and `irq`=0 the next cycle, staying low.
- EN=8'hFF, rise `src`[5] and `src`[1] together:
  - -> `irq_addr`=16'h0004 first.
  - After ack, `irq` low 1 cycle, then `irq_addr`=16'h000C.
  - Second ack -> `irq`=0.
- EN=0, rise `src`[3] -> PEND=8'h08, `irq`=0. Write EN=8'h08 -> `irq`=1 after the next edge. Write PEND=8'h08 -> `irq` falls.
- Same-cycle PEND write-1 on bit 0 and `src`[0] rise -> PEND[0] remains 1. SET write 8'h80 with EN=8'h80 -> `irq_addr`=16'h0010.
- Assert `reset` while `irq`=1 -> `irq`=0, `irq_addr`=16'h0002, EN/PEND read 8'h00. `io_addr`=8'h30 -> `io_rdata`=8'h00.
